// File: rtl/dm_cache_controller.sv
// Direct-mapped cache controller: tag store, hit/miss FSM,
// read-miss line refill and write-through stores.
module dm_cache_controller #(
  parameter int ADDR_LEN     = 32,
  parameter int INDEX_LEN    = 6,
  parameter int OFFSET_LEN   = 4,
  parameter int WORD_S       = 32,
  parameter int CACHE_L_SIZE = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req_valid,
  output logic                    cpu_req_ready,
  input  logic                    cpu_req_write,
  input  logic [ADDR_LEN-1:0]     cpu_req_addr,
  input  logic [WORD_S-1:0]       cpu_req_wdata,
  output logic                    cpu_resp_valid,
  output logic [WORD_S-1:0]       cpu_resp_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [ADDR_LEN-1:0]     mem_req_addr,
  output logic [WORD_S-1:0]       mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [CACHE_L_SIZE-1:0] mem_resp_line,
  output logic                    cache_select,
  output logic                    cache_write,
  output logic [INDEX_LEN-1:0]    cache_index,
  output logic [OFFSET_LEN-1:0]   cache_offset,
  output logic [CACHE_L_SIZE-1:0] cache_line_data,
  output logic [WORD_S-1:0]       cache_word_data,
  input  logic [CACHE_L_SIZE-1:0] cache_dout
);

  localparam int TAG_LEN = ADDR_LEN - INDEX_LEN - OFFSET_LEN;
  localparam int LINES   = 2 ** INDEX_LEN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_LEN-1:0] r_addr;
  logic [WORD_S-1:0]   r_wdata;
  logic [WORD_S-1:0]   r_rdata;
  logic                r_write;
  logic [LINES-1:0]    r_valid;
  logic [TAG_LEN-1:0]  r_tag [LINES];
  logic                r_hit_v;
  logic [TAG_LEN-1:0]  r_hit_tag;

  logic [INDEX_LEN-1:0]    w_req_idx;
  logic [INDEX_LEN-1:0]    w_idx;
  logic [TAG_LEN-1:0]      w_tag;
  logic [OFFSET_LEN-1:0]   w_off;
  logic [OFFSET_LEN-3:0]   w_wsel;
  logic                    w_hit;
  logic                    w_accept;
  logic                    w_fill;
  logic [WORD_S-1:0]       w_dout_word;
  logic [WORD_S-1:0]       w_line_word;

  assign w_req_idx   = cpu_req_addr[OFFSET_LEN +: INDEX_LEN];
  assign w_idx       = r_addr[OFFSET_LEN +: INDEX_LEN];
  assign w_tag       = r_addr[ADDR_LEN-1 -: TAG_LEN];
  assign w_off       = r_addr[OFFSET_LEN-1:0];
  assign w_wsel      = w_off[OFFSET_LEN-1:2];
  assign w_hit       = r_hit_v && (r_hit_tag == w_tag);
  assign w_accept    = (r_state == S_IDLE) && cpu_req_valid;
  assign w_fill      = (r_state == S_RD_WAIT) && mem_resp_valid;
  assign w_dout_word = cache_dout[w_wsel*WORD_S +: WORD_S];
  assign w_line_word = mem_resp_line[w_wsel*WORD_S +: WORD_S];

  // Tag/valid lookup is registered so it lines up with cache_dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_rdata   <= '0;
      r_hit_v   <= 1'b0;
      r_hit_tag <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr    <= cpu_req_addr;
        r_wdata   <= cpu_req_wdata;
        r_write   <= cpu_req_write;
        r_rdata   <= '0;
        r_hit_v   <= r_valid[w_req_idx];
        r_hit_tag <= r_tag[w_req_idx];
      end
      if (r_state == S_LOOKUP && !r_write && w_hit)
        r_rdata <= w_dout_word;
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_rdata        <= w_line_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill)
      r_tag[w_idx] <= w_tag;
  end

  always_comb begin
    w_next          = r_state;
    cpu_req_ready   = 1'b0;
    cpu_resp_valid  = 1'b0;
    cpu_resp_rdata  = '0;
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = '0;
    mem_req_wdata   = '0;
    cache_select    = 1'b0;
    cache_write     = 1'b0;
    cache_index     = '0;
    cache_offset    = '0;
    cache_line_data = '0;
    cache_word_data = '0;
    unique case (r_state)
      S_IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          cache_index = w_req_idx;
          w_next      = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        cache_index = w_idx;
        if (r_write) begin
          w_next = S_WR_REQ;
          if (w_hit) begin
            cache_write     = 1'b1;
            cache_offset    = w_off;
            cache_word_data = r_wdata;
          end
        end else if (w_hit) begin
          w_next = S_RESP;
        end else begin
          w_next = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        cache_index   = w_idx;
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_addr[ADDR_LEN-1:OFFSET_LEN],
                         {OFFSET_LEN{1'b0}}};
        if (mem_req_ready)
          w_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        cache_index = w_idx;
        if (mem_resp_valid) begin
          cache_write     = 1'b1;
          cache_select    = 1'b1;
          cache_line_data = mem_resp_line;
          w_next          = S_RESP;
        end
      end
      S_WR_REQ: begin
        cache_index   = w_idx;
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = r_addr;
        mem_req_wdata = r_wdata;
        if (mem_req_ready)
          w_next = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        cache_index = w_idx;
        if (mem_resp_valid)
          w_next = S_RESP;
      end
      S_RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_rdata = r_rdata;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Scoreboard bench for dm_cache_controller with a data-array
// model and a delayed-handshake main-memory responder.
module tb_dm_cache_controller;

  logic         clk;
  logic         reset;
  logic         cpu_req_valid;
  logic         cpu_req_ready;
  logic         cpu_req_write;
  logic [31:0]  cpu_req_addr;
  logic [31:0]  cpu_req_wdata;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_resp_rdata;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [31:0]  mem_req_wdata;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_line;
  logic         cache_select;
  logic         cache_write;
  logic [5:0]   cache_index;
  logic [3:0]   cache_offset;
  logic [127:0] cache_line_data;
  logic [31:0]  cache_word_data;
  logic [127:0] cache_dout;

  dm_cache_controller dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_req_ready   (cpu_req_ready),
    .cpu_req_write   (cpu_req_write),
    .cpu_req_addr    (cpu_req_addr),
    .cpu_req_wdata   (cpu_req_wdata),
    .cpu_resp_valid  (cpu_resp_valid),
    .cpu_resp_rdata  (cpu_resp_rdata),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_write   (mem_req_write),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_line   (mem_resp_line),
    .cache_select    (cache_select),
    .cache_write     (cache_write),
    .cache_index     (cache_index),
    .cache_offset    (cache_offset),
    .cache_line_data (cache_line_data),
    .cache_word_data (cache_word_data),
    .cache_dout      (cache_dout)
  );

  typedef struct {
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } rexp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
  } mexp_t;

  rexp_t       exp_q[$];
  mexp_t       mexp_q[$];
  bit   [31:0] mem[bit [31:0]];
  logic [127:0] arr[64];
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          resp_lat;
  int          hs_cnt;
  bit          busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // Data array: registered read, word or line write.
  initial begin
    for (int i = 0; i < 64; i++) arr[i] = '0;
    cache_dout = '0;
  end
  always @(posedge clk) begin
    if (cache_write) begin
      if (cache_select)
        arr[cache_index] <= cache_line_data;
      else
        arr[cache_index][cache_offset[3:2]*32 +: 32] <= cache_word_data;
    end
    cache_dout <= arr[cache_index];
  end

  // CPU response monitor.
  always @(negedge clk) begin
    if (cpu_resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        rexp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", cpu_resp_rdata, e.rdata);
        if (e.lat >= 0)
          chk("hit_latency", cyc - e.acc, e.lat);
      end
    end
  end

  // Memory responder: ready one cycle late, response resp_lat later.
  initial begin
    logic [31:0]  ca;
    logic [31:0]  cd;
    logic         cw;
    logic [31:0]  base;
    logic [127:0] ln;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_line  = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && !reset) begin
        busy = 1'b1;
        ca = mem_req_addr;
        cw = mem_req_write;
        cd = mem_req_wdata;
        @(negedge clk);
        chk("mem_hold_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("mem_hold_addr", mem_req_addr, ca);
        mem_req_ready = 1'b1;
        if (mexp_q.size() == 0) begin
          chk("mem_unexpected", ca, 32'hFFFF_FFFF);
        end else begin
          mexp_t m;
          m = mexp_q.pop_front();
          chk("mem_write", {31'd0, cw}, {31'd0, m.wr});
          chk("mem_addr", ca, m.addr);
          if (m.wr) chk("mem_wdata", cd, m.wd);
        end
        if (cw) mem[ca] = cd;
        hs_cnt++;
        @(negedge clk);
        mem_req_ready = 1'b0;
        repeat (resp_lat) @(negedge clk);
        base = {ca[31:4], 4'h0};
        for (int k = 0; k < 4; k++) ln[k*32 +: 32] = rd(base + 32'(4*k));
        mem_resp_line  = cw ? '0 : ln;
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_line  = '0;
        busy = 1'b0;
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ex,
                        input int lat, input bit want);
    int t;
    t = 0;
    @(negedge clk);
    while (!cpu_req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!cpu_req_ready) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_req_addr  = a;
    cpu_req_wdata = wd;
    if (want) exp_q.push_back('{ex, cyc, lat});
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mexp_q.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      chk("done_timeout", 32'd0, 32'd1);
      exp_q.delete();
      mexp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outs();
    chk("rst_req_ready", {31'd0, cpu_req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_cache_write", {31'd0, cache_write}, 32'd0);
  endtask

  function automatic void exp_mem(input logic wr, input logic [31:0] a,
                                  input logic [31:0] wd);
    mexp_q.push_back('{wr, a, wd});
  endfunction

  initial begin
    int t;
    cyc = 0; n_checks = 0; n_fail = 0;
    resp_lat = 2; hs_cnt = 0; busy = 1'b0;
    reset = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs();
    chk("rst_mem_addr", mem_req_addr, 32'd0);
    reset = 1'b0;

    exp_mem(1'b0, 32'h40, 32'h0);
    do_req(1'b0, 32'h40, 32'h0, 32'hA5A5_0040, -1, 1'b1);
    wait_done();
    do_req(1'b0, 32'h48, 32'h0, 32'hA5A5_0048, 2, 1'b1);
    wait_done();
    exp_mem(1'b1, 32'h44, 32'hDEAD_BEEF);
    do_req(1'b1, 32'h44, 32'hDEAD_BEEF, 32'h0, -1, 1'b1);
    wait_done();
    chk("array_word1_line4", arr[4][63:32], 32'hDEAD_BEEF);
    do_req(1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 2, 1'b1);
    wait_done();
    exp_mem(1'b1, 32'h1000, 32'h1234_5678);
    do_req(1'b1, 32'h1000, 32'h1234_5678, 32'h0, -1, 1'b1);
    wait_done();
    chk("store_miss_no_alloc", arr[0][31:0], 32'h0);
    exp_mem(1'b0, 32'h1000, 32'h0);
    do_req(1'b0, 32'h1000, 32'h0, 32'h1234_5678, -1, 1'b1);
    wait_done();
    exp_mem(1'b0, 32'h440, 32'h0);
    do_req(1'b0, 32'h440, 32'h0, 32'hA5A5_0440, -1, 1'b1);
    wait_done();
    exp_mem(1'b0, 32'h40, 32'h0);
    do_req(1'b0, 32'h40, 32'h0, 32'hA5A5_0040, -1, 1'b1);
    wait_done();
    do_req(1'b0, 32'h44, 32'h0, 32'hDEAD_BEEF, 2, 1'b1);
    wait_done();

    // Abort a refill with reset; its late response must be ignored.
    resp_lat = 8;
    t = hs_cnt;
    exp_mem(1'b0, 32'h2000, 32'h0);
    do_req(1'b0, 32'h2000, 32'h0, 32'h0, -1, 1'b0);
    for (int i = 0; i < 50 && hs_cnt == t; i++) @(negedge clk);
    chk("abort_handshake", hs_cnt - t, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outs();
    reset = 1'b0;
    repeat (12) @(negedge clk);
    resp_lat = 2;
    wait_done();

    exp_mem(1'b0, 32'h40, 32'h0);
    do_req(1'b0, 32'h48, 32'h0, 32'hA5A5_0048, -1, 1'b1);
    wait_done();
    exp_mem(1'b0, 32'h1000, 32'h0);
    do_req(1'b0, 32'h1000, 32'h0, 32'h1234_5678, -1, 1'b1);
    wait_done();

    chk("resp_queue_empty", exp_q.size(), 32'd0);
    chk("mem_queue_empty", mexp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
